// File: rtl/reg_decoder_pkg.sv
// Shared sizing helpers and types for the register-file write decoder.
package reg_decoder_pkg;

  localparam int COUNT_W     = 16;
  localparam int ADDR_W_DFLT = 5;

  function automatic int nreg(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef logic [COUNT_W-1:0]              count_t;
  typedef logic [nreg(ADDR_W_DFLT)-1:0]    strobe_t;

endpackage

// File: rtl/one_hot_decoder.sv
// N-to-2**N one-hot decode with enable; output is all zero when disabled.
module one_hot_decoder #(
  parameter int ADDR_W = 5
) (
  output logic [(1 << ADDR_W)-1:0] out,
  input  logic [ADDR_W-1:0]        in,
  input  logic                     enable
);

  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/reg_write_decoder.sv
// Registered multi-channel register-file write decoder with fixed channel priority,
// zero-register suppression, stall/flush handling and a saturating write counter.
module reg_write_decoder
  import reg_decoder_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int CH          = 2,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CH-1:0]             en,
  input  logic [CH*ADDR_W-1:0]      addr,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      clr_conflict,
  output logic [nreg(ADDR_W)-1:0]   wr_strobe,
  output logic [CH-1:0]             grant,
  output logic                      conflict,
  output logic                      conflict_sticky,
  output logic [COUNT_W-1:0]        wr_count
);

  localparam int NREG = nreg(ADDR_W);
  localparam int PC_W = $clog2(CH + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NREG - 1);

  typedef logic [NREG-1:0] strobe_w_t;

  logic [CH-1:0]        w_accept;
  logic                 w_conflict;
  strobe_w_t            w_dec [CH];
  strobe_w_t            w_strobe_next;
  logic [PC_W-1:0]      w_pop;
  logic [COUNT_W:0]     w_sum;
  logic [COUNT_W-1:0]   w_count_next;

  strobe_w_t            r_wr_strobe;
  logic [CH-1:0]        r_grant;
  logic                 r_conflict;
  logic                 r_sticky;
  logic [COUNT_W-1:0]   r_wr_count;

  // A channel only loses to a lower-index channel that was itself accepted.
  always_comb begin
    logic [CH-1:0] acc;
    logic          valid;
    logic          taken;
    acc        = '0;
    w_conflict = 1'b0;
    for (int c = 0; c < CH; c++) begin
      valid = en[c] && !((ZERO_REG_EN != 0) && (addr[c*ADDR_W +: ADDR_W] == ZERO_ADDR));
      taken = 1'b0;
      for (int j = 0; j < c; j++) begin
        if (acc[j] && (addr[j*ADDR_W +: ADDR_W] == addr[c*ADDR_W +: ADDR_W])) taken = 1'b1;
      end
      acc[c] = valid && !taken;
      if (valid && taken) w_conflict = 1'b1;
    end
    w_accept = acc;
  end

  for (genvar g = 0; g < CH; g++) begin : g_dec
    one_hot_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .out    (w_dec[g]),
      .in     (addr[g*ADDR_W +: ADDR_W]),
      .enable (w_accept[g])
    );
  end

  always_comb begin
    w_strobe_next = '0;
    w_pop         = '0;
    for (int c = 0; c < CH; c++) begin
      w_strobe_next = w_strobe_next | w_dec[c];
      w_pop         = w_pop + PC_W'(w_accept[c]);
    end
  end

  assign w_sum        = (COUNT_W+1)'(r_wr_count) + (COUNT_W+1)'(w_pop);
  assign w_count_next = w_sum[COUNT_W] ? '1 : w_sum[COUNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_strobe <= '0;
      r_grant     <= '0;
      r_conflict  <= 1'b0;
      r_sticky    <= 1'b0;
      r_wr_count  <= '0;
    end else begin
      if (flush) begin
        r_wr_strobe <= '0;
        r_grant     <= '0;
        r_conflict  <= 1'b0;
      end else if (!stall) begin
        r_wr_strobe <= w_strobe_next;
        r_grant     <= w_accept;
        r_conflict  <= w_conflict;
        r_wr_count  <= w_count_next;
      end
      // Set only when a fresh conflict is actually loaded; set wins over clear.
      if (!flush && !stall && w_conflict) r_sticky <= 1'b1;
      else if (clr_conflict)              r_sticky <= 1'b0;
    end
  end

  assign wr_strobe       = r_wr_strobe;
  assign grant           = r_grant;
  assign conflict        = r_conflict;
  assign conflict_sticky = r_sticky;
  assign wr_count        = r_wr_count;

endmodule

// File: tb/tb_reg_write_decoder.sv
// Randomised self-checking bench for reg_write_decoder against a behavioural model.
module tb_reg_write_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic [9:0]  addr;
  logic        stall, flush, clr_conflict;
  logic [31:0] wr_strobe;
  logic [1:0]  grant;
  logic        conflict, conflict_sticky;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_strobe;
  logic [1:0]  m_grant;
  logic        m_conf, m_sticky;
  int          m_count;

  reg_write_decoder #(.ADDR_W(5), .CH(2), .ZERO_REG_EN(1)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .stall(stall), .flush(flush),
    .clr_conflict(clr_conflict), .wr_strobe(wr_strobe), .grant(grant),
    .conflict(conflict), .conflict_sticky(conflict_sticky), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_strobe = '0; m_grant = '0; m_conf = 0; m_sticky = 0; m_count = 0;
  endtask

  // Model the edge from the currently applied inputs, then advance past it.
  task automatic tick();
    int a [2];
    bit claimed [32];
    logic [31:0] s;
    logic [1:0]  g;
    bit cf;
    int n;
    a[0] = int'(addr[4:0]);
    a[1] = int'(addr[9:5]);
    if (flush) begin
      m_strobe = '0; m_grant = '0; m_conf = 0;
      if (clr_conflict) m_sticky = 0;
    end else if (stall) begin
      if (clr_conflict) m_sticky = 0;
    end else begin
      foreach (claimed[k]) claimed[k] = 0;
      s = '0; g = '0; cf = 0; n = 0;
      for (int c = 0; c < 2; c++) begin
        if (en[c] && a[c] != 31) begin
          if (claimed[a[c]]) cf = 1;
          else begin
            claimed[a[c]] = 1;
            s = s | (32'd1 << a[c]);
            g[c] = 1'b1;
            n++;
          end
        end
      end
      m_strobe = s; m_grant = g; m_conf = cf;
      m_count = (m_count + n > 65535) ? 65535 : m_count + n;
      if (cf) m_sticky = 1;
      else if (clr_conflict) m_sticky = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] e, input int a0, input int a1);
    en = e;
    addr = {5'(a1), 5'(a0)};
  endtask

  task automatic test_reset();
    reset = 0; en = 0; addr = 0; stall = 0; flush = 0; clr_conflict = 0;
    model_reset();
    #12;
    total++;
    if ({wr_strobe, grant, conflict, conflict_sticky, wr_count} !== 52'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {wr_strobe, grant, conflict, conflict_sticky, wr_count});
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_single();
    set_in(2'b01, 3, 0);
    tick();
    total++;
    if (wr_strobe !== 32'h0000_0008 || grant !== 2'b01 || conflict !== 1'b0 || wr_count !== 16'd1) begin
      bad++;
      $display("FAIL single_write got strobe=%h grant=%b conf=%b cnt=%0d exp 00000008/01/0/1",
               wr_strobe, grant, conflict, wr_count);
    end
  endtask

  task automatic test_collision();
    set_in(2'b11, 7, 7);
    tick();
    total++;
    if (wr_strobe !== 32'h0000_0080 || grant !== 2'b01 || conflict !== 1'b1 || conflict_sticky !== 1'b1) begin
      bad++;
      $display("FAIL collision got strobe=%h grant=%b conf=%b sticky=%b exp 00000080/01/1/1",
               wr_strobe, grant, conflict, conflict_sticky);
    end
    set_in(2'b00, 0, 0);
    tick();
    total++;
    if (conflict !== 1'b0 || conflict_sticky !== 1'b1) begin
      bad++;
      $display("FAIL conflict_pulse got conf=%b sticky=%b exp 0/1", conflict, conflict_sticky);
    end
    clr_conflict = 1;
    tick();
    clr_conflict = 0;
    total++;
    if (conflict_sticky !== 1'b0) begin
      bad++;
      $display("FAIL sticky_clear got=%b exp=0", conflict_sticky);
    end
  endtask

  task automatic test_zero_reg();
    set_in(2'b11, 31, 2);
    tick();
    total++;
    if (wr_strobe !== 32'h0000_0004 || grant !== 2'b10 || conflict !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg got strobe=%h grant=%b conf=%b exp 00000004/10/0", wr_strobe, grant, conflict);
    end
    set_in(2'b11, 31, 31);
    tick();
    total++;
    if (wr_strobe !== 32'h0 || grant !== 2'b00 || conflict !== 1'b0 || conflict_sticky !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg_both got strobe=%h grant=%b conf=%b sticky=%b exp 0/00/0/0",
               wr_strobe, grant, conflict, conflict_sticky);
    end
  endtask

  task automatic test_stall_flush();
    logic [51:0] snap;
    set_in(2'b01, 4, 0);
    tick();
    snap = {wr_strobe, grant, conflict, conflict_sticky, wr_count};
    total++;
    if (wr_strobe !== 32'h0000_0010) begin
      bad++;
      $display("FAIL pre_stall got=%h exp=00000010", wr_strobe);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, $urandom_range(0, 30), $urandom_range(0, 30));
      tick();
      total++;
      if ({wr_strobe, grant, conflict, conflict_sticky, wr_count} !== snap) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i,
                 {wr_strobe, grant, conflict, conflict_sticky, wr_count}, snap);
      end
    end
    flush = 1;
    tick();
    total++;
    if (wr_strobe !== 32'h0 || grant !== 2'b00 || wr_count !== snap[15:0]) begin
      bad++;
      $display("FAIL flush_stall got strobe=%h grant=%b cnt=%0d exp 0/00/%0d",
               wr_strobe, grant, wr_count, snap[15:0]);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = 2'($urandom);
      addr[4:0] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      addr[9:5] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      clr_conflict = ($urandom_range(0, 5) == 0);
      tick();
      total++;
      if ({wr_strobe, grant, conflict, conflict_sticky, wr_count} !==
          {m_strobe, m_grant, m_conf, m_sticky, 16'(m_count)}) begin
        bad++;
        $display("FAIL random cyc=%0d got strobe=%h g=%b c=%b s=%b n=%0d exp strobe=%h g=%b c=%b s=%b n=%0d",
                 i, wr_strobe, grant, conflict, conflict_sticky, wr_count,
                 m_strobe, m_grant, m_conf, m_sticky, m_count);
      end
    end
    stall = 0; flush = 0; clr_conflict = 0;
  endtask

  task automatic test_set_beats_clear();
    set_in(2'b11, 5, 5);
    clr_conflict = 1;
    tick();
    clr_conflict = 0;
    total++;
    if (conflict_sticky !== 1'b1 || conflict !== 1'b1) begin
      bad++;
      $display("FAIL set_beats_clear got sticky=%b conf=%b exp 1/1", conflict_sticky, conflict);
    end
  endtask

  task automatic test_async_reset();
    set_in(2'b11, 9, 10);
    stall = 1;
    tick();
    #3;
    reset = 0;
    #1;
    total++;
    if ({wr_strobe, grant, conflict, conflict_sticky, wr_count} !== 52'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {wr_strobe, grant, conflict, conflict_sticky, wr_count});
    end
    model_reset();
    stall = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_saturation();
    set_in(2'b11, 0, 1);
    for (int i = 0; i < 32767; i++) tick();
    total++;
    if (wr_count !== 16'hFFFE || m_count != 65534) begin
      bad++;
      $display("FAIL sat_preload got=%h exp=fffe", wr_count);
    end
    tick();
    total++;
    if (wr_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_reach got=%h exp=ffff", wr_count);
    end
    tick();
    tick();
    total++;
    if (wr_count !== 16'hFFFF || wr_count !== 16'(m_count)) begin
      bad++;
      $display("FAIL sat_hold got=%h exp=ffff", wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_zero_reg();
    test_stall_flush();
    test_set_beats_clear();
    test_random();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
